// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, bit positions, cause codes, access encodings and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MIP_MEI        = 11;
  localparam int MIP_MTI        = 7;
  localparam int IRQ_LOCAL_BASE = 16;

  localparam logic [4:0] CAUSE_MEI = 5'd11;
  localparam logic [4:0] CAUSE_MTI = 5'd7;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  function automatic logic [63:0] csr_apply(input logic [1:0] op, input logic [63:0] old_v,
                                            input logic [63:0] wdata);
    logic [63:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_v | wdata;
      CSR_OP_RC: res = old_v & ~wdata;
      default:   res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Core <-> CSR/trap unit bundle: CSR access port plus trap/mret requests and
// the registered redirect/acknowledge returned to the core.
interface csr_trap_unit_if #(
  parameter int XLEN    = 64,
  parameter int NUM_IRQ = 4
);
  logic               csr_req;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic [XLEN-1:0]    csr_rdata;
  logic               csr_illegal;
  logic               int_window;
  logic [XLEN-1:0]    pc_cur;
  logic               exc_req;
  logic [4:0]         exc_cause;
  logic [XLEN-1:0]    exc_tval;
  logic               mret_req;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic [NUM_IRQ+1:0] irq_ack;

  modport master (
    output csr_req, csr_op, csr_addr, csr_wdata, int_window, pc_cur,
           exc_req, exc_cause, exc_tval, mret_req,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, irq_ack
  );

  modport slave (
    input  csr_req, csr_op, csr_addr, csr_wdata, int_window, pc_cur,
           exc_req, exc_cause, exc_tval, mret_req,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc, irq_ack
  );
endinterface

// File: rtl/irq_sync.sv
// N-bit two-flop synchroniser for asynchronous level interrupt requests.
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // two-stage metastability filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: prioritised interrupts, synchronous
// exceptions, mret, and a one-cycle registered PC redirect back to the core.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              NUM_IRQ     = 4,
  parameter int unsigned     HART_ID     = 0,
  parameter logic            MIE_RESET   = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               ext_irq,
  input  logic               timer_irq,
  csr_trap_unit_if.slave     bus
);
  localparam logic [XLEN-1:0] MISA_VAL = (XLEN'(2) << (XLEN - 2)) | (XLEN'(1) << 8);
  localparam logic [XLEN-1:0] IRQ_MASK = (XLEN'(1) << MIP_MEI) | (XLEN'(1) << MIP_MTI) |
                                         (((XLEN'(1) << NUM_IRQ) - XLEN'(1)) << IRQ_LOCAL_BASE);

  logic [NUM_IRQ+1:0] sync_s, int_ack_s, ack_nxt_s, irq_ack_r;
  logic [XLEN-1:0]    mip_s, pend_s, mstatus_s, rdata_s, wr_val_s, base_s, target_s;
  logic [XLEN-1:0]    mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r, mcycle_r, redirect_pc_r;
  logic               mstatus_mie_r, mstatus_mpie_r, redirect_valid_r;
  logic               legal_s, illegal_s, wr_en_s, trap_s, mret_s, intr_s;
  logic [4:0]         int_cause_s, cause_s;
  trap_state_e        state_r, state_nxt_s;

  // ack bit order {local, ext, timer} matches irq_ack so one index serves both
  irq_sync #(.WIDTH(NUM_IRQ + 2)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({irq_lines, ext_irq, timer_irq}),
    .q     (sync_s)
  );

  // synchronised levels placed at their mip bit positions
  always_comb begin
    mip_s                                = '0;
    mip_s[MIP_MTI]                       = sync_s[0];
    mip_s[MIP_MEI]                       = sync_s[1];
    mip_s[IRQ_LOCAL_BASE +: NUM_IRQ]     = sync_s[NUM_IRQ+1:2];
  end

  assign pend_s    = mip_s & mie_r & {XLEN{mstatus_mie_r}};
  assign mstatus_s = (XLEN'(3) << 11) | (XLEN'(mstatus_mpie_r) << MSTATUS_MPIE) |
                     (XLEN'(mstatus_mie_r) << MSTATUS_MIE);

  // interrupt priority: ext, then timer, then lowest-numbered local line
  always_comb begin
    int_cause_s = 5'd0;
    int_ack_s   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      int_cause_s = pend_s[IRQ_LOCAL_BASE+i] ? 5'(IRQ_LOCAL_BASE + i) : int_cause_s;
      int_ack_s   = pend_s[IRQ_LOCAL_BASE+i] ? ((NUM_IRQ+2)'(1) << (i + 2)) : int_ack_s;
    end
    int_cause_s = pend_s[MIP_MTI] ? CAUSE_MTI : int_cause_s;
    int_ack_s   = pend_s[MIP_MTI] ? (NUM_IRQ+2)'(1) : int_ack_s;
    int_cause_s = pend_s[MIP_MEI] ? CAUSE_MEI : int_cause_s;
    int_ack_s   = pend_s[MIP_MEI] ? (NUM_IRQ+2)'(2) : int_ack_s;
  end

  // CSR read mux and address decode
  always_comb begin
    rdata_s = '0;
    legal_s = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS:  rdata_s = mstatus_s;
      CSR_MISA:     rdata_s = MISA_VAL;
      CSR_MIE:      rdata_s = mie_r;
      CSR_MTVEC:    rdata_s = mtvec_r;
      CSR_MSCRATCH: rdata_s = mscratch_r;
      CSR_MEPC:     rdata_s = mepc_r;
      CSR_MCAUSE:   rdata_s = mcause_r;
      CSR_MTVAL:    rdata_s = mtval_r;
      CSR_MIP:      rdata_s = mip_s;
      CSR_MCYCLE:   rdata_s = mcycle_r;
      CSR_MHARTID:  rdata_s = XLEN'(HART_ID);
      default: begin
        rdata_s = '0;
        legal_s = 1'b0;
      end
    endcase
  end

  assign illegal_s = bus.csr_req &&
                     (!legal_s || (bus.csr_op != CSR_OP_READ && bus.csr_addr[11:10] == 2'b11));
  assign wr_val_s  = XLEN'(csr_apply(bus.csr_op, 64'(rdata_s), 64'(bus.csr_wdata)));
  assign base_s    = {mtvec_r[XLEN-1:2], 2'b00};
  assign target_s  = (intr_s && mtvec_r[1:0] == 2'b01) ? base_s + XLEN'({cause_s, 2'b00}) : base_s;

  // trap/mret arbitration and next state
  always_comb begin
    state_nxt_s = state_r;
    trap_s      = 1'b0;
    mret_s      = 1'b0;
    intr_s      = 1'b0;
    cause_s     = 5'd0;
    ack_nxt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (bus.exc_req) begin
          trap_s      = 1'b1;
          cause_s     = bus.exc_cause;
          state_nxt_s = ST_REDIRECT;
        end else if ((|pend_s) && bus.int_window) begin
          trap_s      = 1'b1;
          intr_s      = 1'b1;
          cause_s     = int_cause_s;
          ack_nxt_s   = int_ack_s;
          state_nxt_s = ST_REDIRECT;
        end else if (bus.mret_req) begin
          mret_s      = 1'b1;
          state_nxt_s = ST_REDIRECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REDIRECT: state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  assign wr_en_s = bus.csr_req && !illegal_s && bus.csr_op != CSR_OP_READ &&
                   state_r == ST_IDLE && !trap_s && !mret_s;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // architectural CSR state; a trap or mret discards a same-cycle CSR write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_r  <= MIE_RESET;
      mstatus_mpie_r <= 1'b0;
      mie_r          <= '0;
      mtvec_r        <= MTVEC_RESET;
      mscratch_r     <= '0;
      mepc_r         <= '0;
      mcause_r       <= '0;
      mtval_r        <= '0;
      mcycle_r       <= '0;
    end else begin
      mcycle_r <= mcycle_r + XLEN'(1);
      if (trap_s) begin
        mepc_r         <= bus.pc_cur & ~XLEN'(3);
        mcause_r       <= {intr_s, {(XLEN-6){1'b0}}, cause_s};
        mtval_r        <= intr_s ? '0 : bus.exc_tval;
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
      end else if (mret_s) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
      end else if (wr_en_s) begin
        case (bus.csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_r  <= wr_val_s[MSTATUS_MIE];
            mstatus_mpie_r <= wr_val_s[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_r      <= wr_val_s & IRQ_MASK;
          CSR_MTVEC:    mtvec_r    <= {wr_val_s[XLEN-1:2], wr_val_s[1] ? 2'b00 : wr_val_s[1:0]};
          CSR_MSCRATCH: mscratch_r <= wr_val_s;
          CSR_MEPC:     mepc_r     <= wr_val_s & ~XLEN'(3);
          CSR_MCAUSE:   mcause_r   <= wr_val_s;
          CSR_MTVAL:    mtval_r    <= wr_val_s;
          CSR_MCYCLE:   mcycle_r   <= wr_val_s;
          default:      mscratch_r <= mscratch_r;
        endcase
      end else begin
        mscratch_r <= mscratch_r;
      end
    end
  end

  // registered redirect pulse and interrupt acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      irq_ack_r        <= '0;
    end else begin
      redirect_valid_r <= trap_s | mret_s;
      irq_ack_r        <= ack_nxt_s;
      if (trap_s)      redirect_pc_r <= target_s;
      else if (mret_s) redirect_pc_r <= mepc_r;
      else             redirect_pc_r <= redirect_pc_r;
    end
  end

  assign bus.csr_rdata      = rdata_s;
  assign bus.csr_illegal    = illegal_s;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.irq_ack        = irq_ack_r;
endmodule
